// File: rtl/control_unit.sv
// Microcoded-style Moore control sequencer for a small 8-bit accumulator CPU.
// Walks fetch/decode/execute states and drives register strobes and bus selects.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [3:0] ccr_result,
    output logic       ir_load,
    output logic       mar_load,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       a_load,
    output logic       b_load,
    output logic       ccr_load,
    output logic [2:0] alu_sel,
    output logic [1:0] bus1_sel,
    output logic [1:0] bus2_sel,
    output logic       write
);

    typedef enum logic [4:0] {
        S_FETCH_0   = 5'd0,  S_FETCH_1   = 5'd1,  S_FETCH_2   = 5'd2,  S_DECODE    = 5'd3,
        S_LDA_IMM_4 = 5'd4,  S_LDA_IMM_5 = 5'd5,  S_LDA_IMM_6 = 5'd6,
        S_LDA_DIR_4 = 5'd7,  S_LDA_DIR_5 = 5'd8,  S_LDA_DIR_6 = 5'd9,  S_LDA_DIR_7 = 5'd10,
        S_LDA_DIR_8 = 5'd11,
        S_STA_DIR_4 = 5'd12, S_STA_DIR_5 = 5'd13, S_STA_DIR_6 = 5'd14, S_STA_DIR_7 = 5'd15,
        S_LDB_IMM_4 = 5'd16, S_LDB_IMM_5 = 5'd17, S_LDB_IMM_6 = 5'd18,
        S_ALU_4     = 5'd19,
        S_BRA_4     = 5'd20, S_BRA_5     = 5'd21, S_BRA_6     = 5'd22,
        S_BEQ_4     = 5'd23
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] alu_op;
    logic       unused_ccr;

    assign unused_ccr = &{1'b0, ccr_result[3], ccr_result[1:0]};

    function automatic logic [2:0] decode_alu(input logic [7:0] op);
        logic [2:0] sel;
        case (op)
            8'h42:   sel = 3'b000;
            8'h43:   sel = 3'b001;
            8'h44:   sel = 3'b010;
            8'h45:   sel = 3'b011;
            8'h46:   sel = 3'b100;
            8'h47:   sel = 3'b101;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH_0;
        else     state <= next_state;
    end

    // ALU operation captured at decode so later ir changes cannot disturb execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   alu_op <= 3'b000;
        else if (state == S_DECODE) alu_op <= decode_alu(ir);
        else                       alu_op <= alu_op;
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state = S_FETCH_0;
        ir_load    = 1'b0;
        mar_load   = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        ccr_load   = 1'b0;
        alu_sel    = 3'b000;
        bus1_sel   = 2'b00;
        bus2_sel   = 2'b00;
        write      = 1'b0;
        case (state)
            S_FETCH_0:   begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_FETCH_1; end
            S_FETCH_1:   begin pc_inc = 1'b1; next_state = S_FETCH_2; end
            S_FETCH_2:   begin bus2_sel = 2'b10; ir_load = 1'b1; next_state = S_DECODE; end
            S_DECODE: begin
                case (ir)
                    8'h86:   next_state = S_LDA_IMM_4;
                    8'h87:   next_state = S_LDA_DIR_4;
                    8'h96:   next_state = S_STA_DIR_4;
                    8'h88:   next_state = S_LDB_IMM_4;
                    8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47: next_state = S_ALU_4;
                    8'h20:   next_state = S_BRA_4;
                    8'h23:   next_state = S_BEQ_4;
                    default: next_state = S_FETCH_0;
                endcase
            end
            S_LDA_IMM_4: begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_LDA_IMM_5; end
            S_LDA_IMM_5: begin pc_inc = 1'b1; next_state = S_LDA_IMM_6; end
            S_LDA_IMM_6: begin bus2_sel = 2'b10; a_load = 1'b1; next_state = S_FETCH_0; end
            S_LDB_IMM_4: begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_LDB_IMM_5; end
            S_LDB_IMM_5: begin pc_inc = 1'b1; next_state = S_LDB_IMM_6; end
            S_LDB_IMM_6: begin bus2_sel = 2'b10; b_load = 1'b1; next_state = S_FETCH_0; end
            S_LDA_DIR_4: begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_LDA_DIR_5; end
            S_LDA_DIR_5: begin pc_inc = 1'b1; next_state = S_LDA_DIR_6; end
            S_LDA_DIR_6: begin bus2_sel = 2'b10; mar_load = 1'b1; next_state = S_LDA_DIR_7; end
            S_LDA_DIR_7: begin next_state = S_LDA_DIR_8; end
            S_LDA_DIR_8: begin bus2_sel = 2'b10; a_load = 1'b1; next_state = S_FETCH_0; end
            S_STA_DIR_4: begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_STA_DIR_5; end
            S_STA_DIR_5: begin pc_inc = 1'b1; next_state = S_STA_DIR_6; end
            S_STA_DIR_6: begin bus2_sel = 2'b10; mar_load = 1'b1; next_state = S_STA_DIR_7; end
            S_STA_DIR_7: begin bus1_sel = 2'b01; write = 1'b1; next_state = S_FETCH_0; end
            S_ALU_4: begin
                bus1_sel   = 2'b10;
                alu_sel    = alu_op;
                a_load     = 1'b1;
                ccr_load   = 1'b1;
                next_state = S_FETCH_0;
            end
            S_BRA_4:     begin bus2_sel = 2'b01; mar_load = 1'b1; next_state = S_BRA_5; end
            S_BRA_5:     begin next_state = S_BRA_6; end
            S_BRA_6:     begin bus2_sel = 2'b10; pc_load = 1'b1; next_state = S_FETCH_0; end
            // Branch not taken skips the operand byte in place
            S_BEQ_4: begin
                if (ccr_result[2]) begin
                    next_state = S_BRA_4;
                end else begin
                    pc_inc     = 1'b1;
                    next_state = S_FETCH_0;
                end
            end
            default:     next_state = S_FETCH_0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, cycle-by-cycle checks of the control_unit output decode per instruction.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic [3:0] ccr_result;
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, write;
    logic [2:0] alu_sel;
    logic [1:0] bus1_sel, bus2_sel;
    logic [14:0] outs;

    int vectors = 0;
    int miscompares = 0;

    control_unit dut (
        .clk(clk), .rst(rst), .ir(ir), .ccr_result(ccr_result),
        .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load), .pc_inc(pc_inc),
        .a_load(a_load), .b_load(b_load), .ccr_load(ccr_load), .alu_sel(alu_sel),
        .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .write(write)
    );

    always #5 clk = ~clk;

    assign outs = {ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load,
                   alu_sel, bus1_sel, bus2_sel, write};

    // Field order: ir_load mar_load pc_load pc_inc a_load b_load ccr_load alu bus1 bus2 write
    localparam logic [14:0] F0    = 15'b0_1_0_0_0_0_0_000_00_01_0;
    localparam logic [14:0] F1    = 15'b0_0_0_1_0_0_0_000_00_00_0;
    localparam logic [14:0] F2    = 15'b1_0_0_0_0_0_0_000_00_10_0;
    localparam logic [14:0] NONE  = 15'b0_0_0_0_0_0_0_000_00_00_0;
    localparam logic [14:0] MARPC = 15'b0_1_0_0_0_0_0_000_00_01_0;
    localparam logic [14:0] PCINC = 15'b0_0_0_1_0_0_0_000_00_00_0;
    localparam logic [14:0] MARMM = 15'b0_1_0_0_0_0_0_000_00_10_0;
    localparam logic [14:0] LDAM  = 15'b0_0_0_0_1_0_0_000_00_10_0;
    localparam logic [14:0] LDBM  = 15'b0_0_0_0_0_1_0_000_00_10_0;
    localparam logic [14:0] STA   = 15'b0_0_0_0_0_0_0_000_01_00_1;
    localparam logic [14:0] PCLD  = 15'b0_0_1_0_0_0_0_000_00_10_0;
    localparam logic [14:0] SUB   = 15'b0_0_0_0_1_0_1_001_10_00_0;
    localparam logic [14:0] ADD   = 15'b0_0_0_0_1_0_1_000_10_00_0;
    localparam logic [14:0] ANDOP = 15'b0_0_0_0_1_0_1_010_10_00_0;
    localparam logic [14:0] INCA  = 15'b0_0_0_0_1_0_1_100_10_00_0;

    task automatic chk(input string tag, input logic [14:0] exp);
        vectors++;
        assert (outs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
    endtask

    // Check the current cycle, then advance to the next cycle's sample point
    task automatic cyc(input string tag, input logic [14:0] exp);
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_f0"}, F0);
        cyc({tag, "_f1"}, F1);
        cyc({tag, "_f2"}, F2);
        cyc({tag, "_dec"}, NONE);
    endtask

    initial begin
        rst = 1'b1;
        ir = 8'h00;
        ccr_result = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold", F0);
        rst = 1'b0;

        ir = 8'h86;
        fetch("lda_imm");
        cyc("lda_imm_c5", MARPC);
        cyc("lda_imm_c6", PCINC);
        cyc("lda_imm_c7", LDAM);

        ir = 8'h43;
        fetch("sub");
        ir = 8'h86;
        cyc("sub_c5", SUB);

        ir = 8'h42;
        fetch("add");
        cyc("add_c5", ADD);

        ir = 8'h44;
        fetch("and");
        cyc("and_c5", ANDOP);

        ir = 8'h46;
        fetch("inca");
        cyc("inca_c5", INCA);

        ir = 8'h88;
        fetch("ldb_imm");
        cyc("ldb_imm_c5", MARPC);
        cyc("ldb_imm_c6", PCINC);
        cyc("ldb_imm_c7", LDBM);

        ir = 8'h87;
        fetch("lda_dir");
        cyc("lda_dir_c5", MARPC);
        cyc("lda_dir_c6", PCINC);
        cyc("lda_dir_c7", MARMM);
        cyc("lda_dir_c8", NONE);
        cyc("lda_dir_c9", LDAM);

        ir = 8'h96;
        fetch("sta_dir");
        cyc("sta_dir_c5", MARPC);
        cyc("sta_dir_c6", PCINC);
        cyc("sta_dir_c7", MARMM);
        cyc("sta_dir_c8", STA);

        ir = 8'h20;
        fetch("bra");
        cyc("bra_c5", MARPC);
        cyc("bra_c6", NONE);
        cyc("bra_c7", PCLD);

        ir = 8'h23;
        ccr_result = 4'b0100;
        fetch("beq_t");
        cyc("beq_t_c5", NONE);
        cyc("beq_t_c6", MARPC);
        cyc("beq_t_c7", NONE);
        cyc("beq_t_c8", PCLD);

        ccr_result = 4'b0000;
        fetch("beq_nt");
        cyc("beq_nt_c5", PCINC);

        ir = 8'hFF;
        fetch("nop");
        cyc("nop_c5", F0);
        cyc("nop_next_f1", F1);
        cyc("nop_next_f2", F2);
        cyc("nop_next_dec", NONE);

        ir = 8'h87;
        fetch("abort");
        cyc("abort_c5", MARPC);
        cyc("abort_c6", PCINC);
        cyc("abort_c7", MARMM);
        chk("abort_c8_wait", NONE);
        rst = 1'b1;
        #1;
        chk("abort_async_rst", F0);
        @(negedge clk);
        chk("abort_rst_held", F0);
        rst = 1'b0;
        ir = 8'h00;
        cyc("abort_rel_f0", F0);
        cyc("abort_rel_f1", F1);
        cyc("abort_rel_f2", F2);
        cyc("abort_rel_dec", NONE);
        cyc("abort_rel_nop_f0", F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; forces state to S_FETCH_0 immediately.
REQ-003 ir  input  8  instruction register contents (opcode).
REQ-004 ccr_result  input  4  latched NZVC flags; bit 2 = Z.
REQ-005 ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load  output  1 each  register load/increment strobes.
REQ-006 alu_sel  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 inc A, 101 dec A.
REQ-007 bus1_sel  output  2  00 PC, 01 A, 10 B.
REQ-008 bus2_sel  output  2  00 ALU result, 01 bus1, 10 from_memory.
REQ-009 write  output  1  memory write strobe at address MAR, data = bus1.

Function
REQ-010 Moore FSM: outputs decode from current state (plus ccr_result for BEQ only); any strobe not listed for a state is 0; bus/alu selects default to 00/000.
REQ-011 Memory read latency is one cycle: data addressed by MAR at edge N is valid on from_memory for edge N+1.
REQ-012 S_FETCH_0: bus1_sel=00, bus2_sel=01, mar_load=1 -> S_FETCH_1.
REQ-013 S_FETCH_1: pc_inc=1 -> S_FETCH_2.
REQ-014 S_FETCH_2: bus2_sel=10, ir_load=1 -> S_DECODE.
REQ-015 S_DECODE: no strobes; next state by ir: 0x86 LDA_IMM, 0x87 LDA_DIR, 0x96 STA_DIR, 0x88 LDB_IMM, 0x42 ADD, 0x43 SUB, 0x44 AND, 0x45 OR, 0x46 INCA, 0x47 DECA, 0x20 BRA, 0x23 BEQ; any other opcode -> S_FETCH_0 (NOP, 4 cycles total).
REQ-016 LDA_IMM/LDB_IMM: S_x_4 (bus1=PC, bus2=bus1, mar_load) -> S_x_5 (pc_inc) -> S_x_6 (bus2=10, a_load or b_load) -> S_FETCH_0; 7 cycles total.
REQ-017 LDA_DIR: MAR<-PC; pc_inc; MAR<-from_memory (bus2=10, mar_load); wait (no strobes); A<-from_memory -> S_FETCH_0; 9 cycles total.
REQ-018 STA_DIR: MAR<-PC; pc_inc; MAR<-from_memory; bus1_sel=01, write=1 -> S_FETCH_0; 8 cycles total.
REQ-019 ALU ops: single state S_ALU_4: bus1_sel=10 (B), alu_sel per opcode, bus2_sel=00, a_load=1, ccr_load=1 -> S_FETCH_0; 5 cycles total.
REQ-020 BRA: MAR<-PC; wait; bus2=10, pc_load=1 -> S_FETCH_0; 7 cycles total.
REQ-021 BEQ: state S_BEQ_4 samples ccr_result[2]; if 1 follow BRA sequence from its first state (7 cycles total after S_BEQ_4 path, i.e. 8); if 0 assert pc_inc in S_BEQ_4 and -> S_FETCH_0 (5 cycles total, operand skipped).
REQ-022 State encoding unspecified; no unreachable state shall lock the FSM: illegal encodings -> S_FETCH_0 next edge.
REQ-023 ir is sampled only in S_DECODE; ir changes in other states have no effect.

Reset
REQ-024 While rst=1: state = S_FETCH_0, outputs equal S_FETCH_0 decode (mar_load=1, bus2_sel=01, all else 0), regardless of clk.
REQ-025 rst asserted mid-instruction aborts it; first rising edge after release executes S_FETCH_0 -> S_FETCH_1.

Verification
REQ-026 Reset release, memory {0:0x86,1:0x5A} -> a_load with bus2_sel=10 in cycle 7; next cycle mar_load with bus1_sel=00.
REQ-027 ir=0x43 at DECODE -> cycle 5: alu_sel=001, bus1_sel=10, bus2_sel=00, a_load=1, ccr_load=1; then S_FETCH_0.
REQ-028 BEQ with ccr_result=0100 -> pc_load=1 at cycle 8; with ccr_result=0000 -> pc_inc=1 at cycle 5, pc_load never asserted.
REQ-029 STA_DIR operand 0xE0 -> write=1, bus1_sel=01 exactly one cycle, cycle 8; write=0 in all other cycles.
REQ-030 Undefined opcode 0xFF -> no strobes after S_FETCH_2; mar_load at cycle 5.
REQ-031 rst pulsed during S_LDA_DIR wait state -> a_load never asserted; outputs at S_FETCH_0 values asynchronously.
